// File: rtl/montgomery.sv
// Radix-2 bit-serial Montgomery multiplier, 1024-bit operands: result = A*B*2^-1024 mod M.
// One iteration per clock over the bits of A (LSB first), then one conditional subtraction.
module montgomery (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [1023:0] in_a,
  input  logic [1023:0] in_b,
  input  logic [1023:0] in_m,
  output logic [1023:0] result,
  output logic          done
);

  localparam int W = 1024;

  typedef enum logic [1:0] {IDLE, RUN, REDUCE, DONE} state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] a_reg, a_next;
  logic [W-1:0] b_reg, b_next;
  logic [W-1:0] m_reg, m_next;
  logic [W+1:0] c_reg, c_next;
  logic [9:0]   i_reg, i_next;
  logic [W-1:0] result_reg, result_next;
  logic         done_reg, done_next;

  logic [W-1:0] b_gated;
  logic [W+2:0] sum_ab;
  logic [W+2:0] sum_abm;
  logic [W+2:0] c_minus_m;
  logic         c_ge_m;
  logic         last_iter;
  logic         unused_bits;

  // Partial product a_i * B: the current LSB of the shifting A gates every bit of B.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_gate
      assign b_gated[gi] = b_reg[gi] & a_reg[0];
    end
  endgenerate

  // One extra bit of headroom over C so even out-of-range operands wrap instead of misbehaving.
  always_comb begin
    sum_ab    = {1'b0, c_reg} + {3'b000, b_gated};
    sum_abm   = sum_ab + (sum_ab[0] ? {3'b000, m_reg} : {(W+3){1'b0}});
    c_minus_m = {1'b0, c_reg} - {3'b000, m_reg};
    c_ge_m    = ~c_minus_m[W+2];
    last_iter = (i_reg == 10'd1023);
  end

  // LSB of sum_abm is always zero after the odd correction; top borrow-free bits are unneeded.
  assign unused_bits = ^{sum_abm[0], c_minus_m[W+1:W]};

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    m_next      = m_reg;
    c_next      = c_reg;
    i_next      = i_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = in_a;
          b_next     = in_b;
          m_next     = in_m;
          c_next     = '0;
          i_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        c_next = sum_abm[W+2:1];
        a_next = {1'b0, a_reg[W-1:1]};
        i_next = i_reg + 10'd1;
        if (last_iter) begin
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        // C < 2M after the loop, so a single subtraction fully reduces it.
        result_next = c_ge_m ? c_minus_m[W-1:0] : c_reg[W-1:0];
        done_next   = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      c_reg      <= '0;
      i_reg      <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      m_reg      <= m_next;
      c_reg      <= c_next;
      i_reg      <= i_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  assign result = result_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_montgomery.sv
// Table-driven, scoreboarded bench for the 1024-bit Montgomery multiplier.
module tb_montgomery;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [1023:0] in_a;
  logic [1023:0] in_b;
  logic [1023:0] in_m;
  logic [1023:0] result;
  logic          done;

  montgomery dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] a;
    logic [1023:0] b;
    logic [1023:0] m;
    logic [1023:0] exp;
    bit            inject;
  } vec_t;

  typedef struct {
    logic [1023:0] a;
    logic [1023:0] b;
    logic [1023:0] m;
    logic [1023:0] exp;
    int unsigned   start_cyc;
  } sb_t;

  sb_t           sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_txn = 0;
  int unsigned   cyc = 0;
  logic [1023:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] v;
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1023:0] rand_mod();
    logic [1023:0] v;
    v = rand_wide();
    v[0] = 1'b1;
    v[1023] = 1'b1;
    return v;
  endfunction

  // Reference: reduce A*B mod M, then divide by 2 modulo M 1024 times.
  function automatic logic [1023:0] model(input logic [1023:0] a, input logic [1023:0] b,
                                          input logic [1023:0] m);
    logic [2047:0] prod;
    logic [1024:0] x;
    prod = {1024'b0, a} * {1024'b0, b};
    prod = prod % {1024'b0, m};
    x = {1'b0, prod[1023:0]};
    for (int k = 0; k < 1024; k++) begin
      if (x[0]) x = x + {1'b0, m};
      x = x >> 1;
    end
    return x[1023:0];
  endfunction

  function automatic vec_t mk(input logic [1023:0] a, input logic [1023:0] b,
                              input logic [1023:0] m, input logic [1023:0] exp, input bit inj);
    vec_t v;
    v.a = a;
    v.b = b;
    v.m = m;
    v.exp = exp;
    v.inject = inj;
    return v;
  endfunction

  task automatic check_eq(input string name, input logic [1023:0] act, input logic [1023:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual (low 128b) %h, required (low 128b) %h", name, act[127:0], req[127:0]);
    end
  endtask

  task automatic monitor();
    logic          done_prev;
    sb_t           e;
    logic [2047:0] lhs;
    logic [2047:0] rhs;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_checks++;
        if (done_prev === 1'b1) begin
          n_fail++;
          $display("FAIL done_width: actual done high for 2+ cycles, required 1 cycle");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: actual done=1, required no pulse (nothing pending)");
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d: m[31:0]=%h latency=%0d result[63:0]=%h expected[63:0]=%h",
                   n_txn, e.m[31:0], cyc - e.start_cyc, result[63:0], e.exp[63:0]);
          check_eq("result", result, e.exp);
          check_eq("latency", 1024'(cyc - e.start_cyc), 1024'd1025);
          lhs = ({1024'b0, result} << 1024) % {1024'b0, e.m};
          rhs = ({1024'b0, e.a} * {1024'b0, e.b}) % {1024'b0, e.m};
          check_eq("congruence", lhs[1023:0], rhs[1023:0]);
        end
      end
      done_prev = done;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 1100 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: actual no done within 1100 cycles, required done pulse");
      sb.delete();
    end
  endtask

  // Called at a negedge; start is sampled on the following rising edge (E0).
  task automatic run_op(input vec_t v);
    sb_t e;
    check_eq("idle_done_low", {1023'b0, done}, 1024'd0);
    in_a = v.a;
    in_b = v.b;
    in_m = v.m;
    start = 1'b1;
    e.a = v.a;
    e.b = v.b;
    e.m = v.m;
    e.exp = v.exp;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_a = rand_wide();
    in_b = rand_wide();
    in_m = rand_mod();
    check_eq("result_hold", result, last_exp);
    if (v.inject) begin
      repeat ($urandom_range(5, 1000)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    last_exp = v.exp;
    if (v.inject) begin
      start = 1'b1;
      in_a = rand_wide();
      in_b = rand_wide();
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vec_t          vecs[14];
    logic [1023:0] m_r;
    logic [1023:0] a_r;
    logic [1023:0] b_r;
    logic [1023:0] all_ones;

    resetn = 1'b0;
    start = 1'b1;
    in_a = 1024'd3;
    in_b = 1024'd5;
    in_m = 1024'd7;
    last_exp = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_eq("reset_result", result, 1024'd0);
    check_eq("reset_done", {1023'b0, done}, 1024'd0);
    start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    all_ones = '1;
    vecs[0] = mk(1024'd3, 1024'd5, 1024'd7, 1024'd4, 1'b0);
    vecs[1] = mk(1024'd1, ~1024'd1, all_ones, ~1024'd1, 1'b0);
    vecs[2] = mk(1024'd3, 1024'd4, 1024'd5, 1024'd2, 1'b0);
    vecs[3] = mk(1024'd2, 1024'd2, 1024'd3, 1024'd1, 1'b0);
    vecs[4] = mk(1024'd2, 1024'd0, rand_mod(), 1024'd0, 1'b0);
    m_r = rand_mod();
    vecs[5] = mk(1024'd0, rand_wide() % m_r, m_r, 1024'd0, 1'b0);
    for (int i = 6; i < 14; i++) begin
      m_r = rand_mod();
      if (i == 13) begin
        a_r = m_r - 1024'd1;
        b_r = m_r - 1024'd1;
      end else begin
        a_r = rand_wide() % m_r;
        b_r = rand_wide() % m_r;
      end
      vecs[i] = mk(a_r, b_r, m_r, model(a_r, b_r, m_r), 1'b1);
    end

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Abort an operation with reset around cycle 500; no done may follow for it.
    in_m = 1024'd7;
    in_a = 1024'd3;
    in_b = 1024'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (498) @(negedge clk);
    resetn = 1'b0;
    start = 1'b1;
    in_a = 1024'd1;
    in_b = 1024'd2;
    in_m = 1024'd3;
    @(negedge clk);
    check_eq("abort_result", result, 1024'd0);
    check_eq("abort_done", {1023'b0, done}, 1024'd0);
    resetn = 1'b1;
    start = 1'b0;
    last_exp = '0;
    @(negedge clk);
    run_op(mk(1024'd1, 1024'd2, 1024'd3, 1024'd2, 1'b0));

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", 1024'(sb.size()), 1024'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
